// File: rtl/alu_exec_seq.sv
// Execution sequencer around a combinational 32-bit ALU: 32x32 register file, IDLE/READ/EXEC/WB.
// Optional overflow trap (suppresses writeback of overflowing add/sub) enabled by ALU_OVF_TRAP_EN.
module alu_exec_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [2:0]  op,
  output logic        busy,
  output logic        done,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_f,
  input  logic        alu_zf,
  input  logic        alu_of,
  output logic [31:0] res_q,
  output logic        zf_q,
  output logic        of_q,
  output logic        ovf_trap,
  input  logic        ext_we,
  input  logic [4:0]  ext_waddr,
  input  logic [31:0] ext_wdata,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e      state_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  op_q;
  logic [31:0] regfile [32];
  logic        wb_suppress;

  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regfile[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regfile[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          // Host write lands on the accepting edge, so READ sees it.
          if (ext_we && (ext_waddr != 5'd0)) begin
            regfile[ext_waddr] <= ext_wdata;
          end
          if (start) begin
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            op_q    <= op;
            busy    <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: begin
          alu_a   <= (rs1_q == 5'd0) ? 32'd0 : regfile[rs1_q];
          alu_b   <= (rs2_q == 5'd0) ? 32'd0 : regfile[rs2_q];
          alu_op  <= op_q;
          state_q <= StExec;
        end
        StExec: begin
          res_q   <= alu_f;
          zf_q    <= alu_zf;
          of_q    <= alu_of;
          state_q <= StWb;
        end
        StWb: begin
          if ((rd_q != 5'd0) && !wb_suppress) begin
            regfile[rd_q] <= res_q;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ALU_OVF_TRAP_EN
  assign wb_suppress = ((alu_op == 3'b100) || (alu_op == 3'b101)) && of_q;

  // Sticky until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_trap <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      ovf_trap <= 1'b0;
    end else if ((state_q == StWb) && wb_suppress) begin
      ovf_trap <= 1'b1;
    end
  end
`else
  assign wb_suppress = 1'b0;
  assign ovf_trap    = 1'b0;
`endif

endmodule
